// File: rtl/mgmt_phy_pkg.sv
// mgmt_phy_pkg: shared K28.5 symbols, 7-bit comma patterns and RX state type
// for the mgmt_phy serial link.
package mgmt_phy_pkg;

  // K28.5 with bit 0 = bit a (first on the wire).
  // RD-: abcdeifghj = 0011111010, RD+: abcdeifghj = 1100000101
  localparam logic [9:0] K285_RDM = 10'h17C;
  localparam logic [9:0] K285_RDP = 10'h283;

  // Comma patterns over window bits [6:0], bit 0 received first.
  localparam logic [6:0] COMMA_RDM = 7'b1111100;  // 0011111
  localparam logic [6:0] COMMA_RDP = 7'b0000011;  // 1100000

  typedef enum logic [1:0] {
    RX_HUNT   = 2'd0,
    RX_CHECK  = 2'd1,
    RX_LOCKED = 2'd2
  } rx_state_t;

  // True when the first seven received bits of a window form a comma.
  function automatic logic is_comma(input logic [9:0] win);
    return (win[6:0] == COMMA_RDM) || (win[6:0] == COMMA_RDP);
  endfunction

endpackage

// File: rtl/mgmt_phy_rx_align.sv
// mgmt_phy_rx_align: 10-bit receive window, comma detection and the
// HUNT/CHECK/LOCKED alignment state machine. Emits aligned symbols while locked.
module mgmt_phy_rx_align
  import mgmt_phy_pkg::*;
#(
  parameter int ALIGN_CNT = 3,
  parameter int LOSS_CNT  = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_bit,
  output logic [9:0] rx_symbol,
  output logic       rx_valid,
  output logic       rx_comma,
  output logic       rx_aligned,
  output logic       align_err
);

  localparam int CW = $clog2(ALIGN_CNT + 1);
  localparam int MW = $clog2(LOSS_CNT + 1);

  logic [9:0]    window;
  logic [3:0]    bit_pos;
  logic [3:0]    boundary, boundary_next;
  rx_state_t     state, state_next;
  logic [CW-1:0] count, count_next, count_inc;
  logic [MW-1:0] miss, miss_next, miss_inc;
  logic          comma, on_bnd, valid_next, err_next;

  assign comma      = is_comma(window);
  assign on_bnd     = (bit_pos == boundary);
  assign count_inc  = count + CW'(1);
  assign miss_inc   = miss + MW'(1);
  assign rx_aligned = (state == RX_LOCKED);

  // Alignment decisions; an off-boundary comma is handled before any boundary event.
  always_comb begin
    state_next    = state;
    boundary_next = boundary;
    count_next    = count;
    miss_next     = miss;
    valid_next    = 1'b0;
    err_next      = 1'b0;
    case (state)
      RX_HUNT: begin
        if (comma) begin
          boundary_next = bit_pos;
          count_next    = CW'(1);
          miss_next     = '0;
          if (CW'(1) == CW'(ALIGN_CNT)) state_next = RX_LOCKED;
          else                          state_next = RX_CHECK;
        end
      end
      RX_CHECK: begin
        if (comma) begin
          if (on_bnd) begin
            count_next = count_inc;
            if (count_inc == CW'(ALIGN_CNT)) begin
              state_next = RX_LOCKED;
              miss_next  = '0;
            end
          end else begin
            // Comma elsewhere: restart qualification at the new boundary.
            boundary_next = bit_pos;
            count_next    = CW'(1);
          end
        end
      end
      RX_LOCKED: begin
        if (comma && !on_bnd) begin
          if (miss_inc == MW'(LOSS_CNT)) begin
            state_next = RX_HUNT;
            err_next   = 1'b1;
            miss_next  = '0;
            count_next = '0;
          end else begin
            miss_next = miss_inc;
          end
        end else if (on_bnd) begin
          valid_next = 1'b1;
          if (comma) miss_next = '0;
        end
      end
      default: state_next = RX_HUNT;
    endcase
  end

  // Shift window (newest bit at 9) and free-running bit position 0..9.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      window  <= '0;
      bit_pos <= '0;
    end else begin
      window  <= {rx_bit, window[9:1]};
      bit_pos <= (bit_pos == 4'd9) ? 4'd0 : bit_pos + 4'd1;
    end
  end

  // State, counters and registered symbol outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RX_HUNT;
      boundary  <= '0;
      count     <= '0;
      miss      <= '0;
      rx_valid  <= 1'b0;
      rx_comma  <= 1'b0;
      rx_symbol <= '0;
      align_err <= 1'b0;
    end else begin
      state     <= state_next;
      boundary  <= boundary_next;
      count     <= count_next;
      miss      <= miss_next;
      rx_valid  <= valid_next;
      rx_comma  <= valid_next && comma;
      align_err <= err_next;
      if (valid_next) rx_symbol <= window;
    end
  end

endmodule

// File: rtl/mgmt_phy.sv
// mgmt_phy: 10-bit serial PHY. TX serialises pre-encoded symbols in fixed
// 10-clock slots, inserting alternating K28.5 idles; RX aligns on commas.
// Optional feature macro: MGMT_PHY_LOOPBACK_EN adds a 'loopback' input that
// routes the ser_tx register back into the receiver.
module mgmt_phy
  import mgmt_phy_pkg::*;
#(
  parameter int ALIGN_CNT = 3,
  parameter int LOSS_CNT  = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] tx_symbol,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       ser_tx,
  input  logic       ser_rx,
`ifdef MGMT_PHY_LOOPBACK_EN
  input  logic       loopback,
`endif
  output logic [9:0] rx_symbol,
  output logic       rx_valid,
  output logic       rx_comma,
  output logic       rx_aligned,
  output logic       align_err
);

  logic [3:0] bit_idx, bit_idx_inc;
  logic [9:0] slot, slot_next;
  logic       idle_rdp;
  logic       rx_bit;

  assign tx_ready    = (bit_idx == 4'd9);
  assign bit_idx_inc = bit_idx + 4'd1;
  assign slot_next   = tx_valid ? tx_symbol : (idle_rdp ? K285_RDP : K285_RDM);

  // TX slot sequencer: ser_tx always carries slot[bit_idx]; new slot loads at index 9.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_idx  <= '0;
      slot     <= K285_RDM;
      idle_rdp <= 1'b1;
      ser_tx   <= 1'b0;
    end else if (tx_ready) begin
      bit_idx <= '0;
      slot    <= slot_next;
      ser_tx  <= slot_next[0];
      if (!tx_valid) idle_rdp <= ~idle_rdp;
    end else begin
      bit_idx <= bit_idx_inc;
      ser_tx  <= slot[bit_idx_inc];
    end
  end

`ifdef MGMT_PHY_LOOPBACK_EN
  assign rx_bit = loopback ? ser_tx : ser_rx;
`else
  assign rx_bit = ser_rx;
`endif

  mgmt_phy_rx_align #(
    .ALIGN_CNT(ALIGN_CNT),
    .LOSS_CNT (LOSS_CNT)
  ) u_rx_align (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_bit    (rx_bit),
    .rx_symbol (rx_symbol),
    .rx_valid  (rx_valid),
    .rx_comma  (rx_comma),
    .rx_aligned(rx_aligned),
    .align_err (align_err)
  );

endmodule

// File: tb/tb_mgmt_phy.sv
// tb_mgmt_phy: randomized self-checking bench for mgmt_phy. A slot-level
// reference model predicts every ser_tx bit and tx_ready; RX expectations are
// derived from the recorded line bit stream and the alignment rules.
module tb_mgmt_phy;

  localparam logic [9:0] RDM = 10'h17C;  // K28.5 RD-  0011111010
  localparam logic [9:0] RDP = 10'h283;  // K28.5 RD+  1100000101

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] tx_symbol = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ser_tx, ser_rx;
  logic [9:0] rx_symbol;
  logic       rx_valid, rx_comma, rx_aligned, align_err;

  logic ext_mode = 1'b0;
  logic ext_bit  = 1'b0;
  logic in_reset = 1'b1;
  int   scen     = 0;    // 0: clean comma start, 1: one inserted bit after slot 5

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign ser_rx = ext_mode ? ext_bit : ser_tx;

  mgmt_phy #(.ALIGN_CNT(3), .LOSS_CNT(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tx_symbol (tx_symbol),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .ser_tx    (ser_tx),
    .ser_rx    (ser_rx),
`ifdef MGMT_PHY_LOOPBACK_EN
    .loopback  (1'b0),
`endif
    .rx_symbol (rx_symbol),
    .rx_valid  (rx_valid),
    .rx_comma  (rx_comma),
    .rx_aligned(rx_aligned),
    .align_err (align_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit data_ok(input logic [9:0] d);
    int run;
    run = 1;
    if (d == 10'h2AA) return 1'b0;
    if (d[0] == d[1] || d[8] == d[9]) return 1'b0;
    for (int i = 1; i < 10; i++) begin
      if (d[i] == d[i-1]) run++;
      else run = 1;
      if (run >= 5) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] d;
    do d = 10'($urandom); while (!data_ok(d));
    return d;
  endfunction

  function automatic logic comma7(input logic [9:0] s);
    return (s[6:0] == 7'b1111100) || (s[6:0] == 7'b0000011);
  endfunction

  // ---------------- reference model (advanced once per cycle) ----------------
  int         cyc;
  logic [9:0] slots[$];
  logic [9:0] idle_next;
  logic       stream[$];
  int         n_2aa = 0, n_ready = 0, n_err = 0;
  logic       exp_bit, exp_aligned, exp_valid, exp_err;
  logic [9:0] exp_sym;

  // Mid-cycle: compare DUT outputs with the model, then advance the model.
  always @(negedge clk) begin
    if (in_reset) begin
      check("rst_ser_tx", ser_tx, 0);
      check("rst_tx_ready", tx_ready, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_comma", rx_comma, 0);
      check("rst_rx_aligned", rx_aligned, 0);
      check("rst_align_err", align_err, 0);
      check("rst_rx_symbol", rx_symbol, 0);
      cyc = 0;
      slots.delete();
      slots.push_back(RDM);
      idle_next = RDP;
      stream.delete();
    end else begin
      exp_bit = slots[cyc/10][cyc%10];
      check("ser_tx", ser_tx, exp_bit);
      check("tx_ready", tx_ready, (cyc % 10) == 9);
      stream.push_back(ext_mode ? ext_bit : exp_bit);

      if (scen == 0) begin
        exp_aligned = (cyc >= 31);
        exp_valid   = (cyc >= 41) && (cyc % 10 == 1);
        exp_err     = 1'b0;
      end else begin
        exp_aligned = (cyc >= 31 && cyc < 82) || (cyc >= 112);
        exp_valid   = (cyc >= 41 && cyc <= 81 && cyc % 10 == 1) ||
                      (cyc >= 122 && cyc % 10 == 2);
        exp_err     = (cyc == 82);
      end
      check("rx_aligned", rx_aligned, exp_aligned);
      check("rx_valid", rx_valid, exp_valid);
      check("align_err", align_err, exp_err);
      if (exp_valid) begin
        for (int i = 0; i < 10; i++) exp_sym[i] = stream[cyc - 11 + i];
        check("rx_symbol", rx_symbol, exp_sym);
        check("rx_comma", rx_comma, comma7(exp_sym));
      end
      if (rx_valid) begin
        $display("rx  cyc=%0d sym=%03h comma=%0b", cyc, rx_symbol, rx_comma);
        if (rx_symbol == 10'h2AA) n_2aa++;
      end
      if (align_err) n_err++;
      if (tx_ready) n_ready++;

      if (cyc % 10 == 9) begin
        if (tx_valid) begin
          slots.push_back(tx_symbol);
          $display("tx  cyc=%0d sym=%03h", cyc, tx_symbol);
        end else begin
          slots.push_back(idle_next);
          idle_next = ~idle_next;
        end
      end
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic enter_reset();
    reset_n  = 1'b0;
    in_reset = 1'b1;
    #1;
    check("async_rst_aligned", rx_aligned, 0);
    check("async_rst_ser_tx", ser_tx, 0);
  endtask

  task automatic leave_reset();
    reset_n  = 1'b1;
    in_reset = 1'b0;
  endtask

  logic ext_q[$];
  logic [9:0] c;

  initial begin
    // Power-on reset
    step(3);
    scen = 0;
    leave_reset();

    // Idle commas only: lock after three slots, comma symbols thereafter
    step(100);

    // One 10'h2AA at the next ready slot, then randomized traffic
    step(9);
    tx_valid  = 1'b1;
    tx_symbol = 10'h2AA;
    step(1);
    tx_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tx_valid  = 1'($urandom_range(0, 1));
      tx_symbol = rand_data();
      step(1);
    end
    tx_valid = 1'b0;
    step(30);
    check("one_rx_for_2aa", n_2aa, 1);

    // tx_valid held high: one acceptance per 10 clocks
    n_ready   = 0;
    tx_valid  = 1'b1;
    tx_symbol = 10'h155;
    step(100);
    check("tx_ready_per_100", n_ready, 10);
    tx_valid = 1'b0;

    // One-clock reset in the middle of a symbol, then full relock
    step(4);
    enter_reset();
    step(1);
    leave_reset();
    step(30);
    check("no_early_relock", rx_aligned, 0);
    step(2);
    check("relock", rx_aligned, 1);
    step(30);

    // External line: six commas, one extra bit, then commas again
    for (int s = 0; s < 6; s++) begin
      c = (s % 2 == 0) ? RDM : RDP;
      for (int b = 0; b < 10; b++) ext_q.push_back(c[b]);
    end
    ext_q.push_back(1'b0);
    for (int s = 6; s < 18; s++) begin
      c = (s % 2 == 0) ? RDM : RDP;
      for (int b = 0; b < 10; b++) ext_q.push_back(c[b]);
    end
    enter_reset();
    step(2);
    ext_mode = 1'b1;
    scen     = 1;
    n_err    = 0;
    ext_bit  = ext_q[0];
    leave_reset();
    for (int k = 1; k < 176; k++) begin
      step(1);
      ext_bit = ext_q[k];
    end
    check("align_err_count", n_err, 1);
    check("final_aligned", rx_aligned, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mgmt_phy.md
MGMT_PHY -- requirements
Module: mgmt_phy

Interface
REQ-001 Parameter ALIGN_CNT, default 3: consecutive on-boundary commas needed to declare alignment.
REQ-002 Parameter LOSS_CNT, default 2: consecutive off-boundary commas that force loss of alignment.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 tx_symbol  in  10  pre-encoded 8b/10b symbol, bit 0 = bit a, sent first.
REQ-007 tx_valid  in  1  tx_symbol valid.
REQ-008 tx_ready  out  1  block accepts tx_symbol this cycle.
REQ-009 ser_tx  out  1  serial line out, one bit per clk.
REQ-010 ser_rx  in  1  serial line in, one bit per clk.
REQ-011 rx_symbol  out  10  received aligned symbol, bit 0 = first received bit.
REQ-012 rx_valid  out  1  one-cycle pulse, rx_symbol valid.
REQ-013 rx_comma  out  1  qualifies rx_valid: symbol is K28.5 (either disparity).
REQ-014 rx_aligned  out  1  high while receiver is LOCKED.
REQ-015 align_err  out  1  one-cycle pulse on LOCKED -> HUNT.

Function
REQ-016 TX SHALL run continuously in 10-clock slots; a 4-bit bit index counts 0..9 and wraps.
REQ-017 ser_tx SHALL be a register driving bit[index] of the current slot symbol.
REQ-018 tx_ready SHALL be high only when index == 9 (one cycle per slot); a transfer occurs when tx_valid && tx_ready.
REQ-019 On transfer, bit a of tx_symbol SHALL appear on ser_tx the next cycle.
REQ-020 With no transfer at index 9, the next slot SHALL carry an idle comma, alternating K28.5 RD- (abcdeifghj 0011111010) and RD+ (1100000101), starting with RD- after reset.
REQ-021 RX SHALL shift ser_rx into a 10-bit window each clk, newest bit at position 9, so a completed symbol has bit a at position 0.
REQ-022 Comma detect: window bits 0..6 equal 0011111 or 1100000 (first-received first).
REQ-023 RX states: HUNT, CHECK, LOCKED.
REQ-024 HUNT: on comma, set boundary at the current bit position, count = 1, go CHECK.
REQ-025 CHECK: on-boundary comma increments count; on-boundary non-comma is ignored; off-boundary comma restarts CHECK at the new boundary with count = 1; at count == ALIGN_CNT go LOCKED.
REQ-026 LOCKED: at every boundary, register rx_symbol = window and pulse rx_valid, with rx_comma = comma detect; outputs are valid one clk after the last bit (j) is sampled.
REQ-027 LOCKED: on-boundary comma clears miss count; off-boundary comma increments it; at miss == LOSS_CNT go HUNT, pulse align_err, and drop rx_aligned the same cycle.
REQ-028 rx_valid SHALL never assert outside LOCKED.
REQ-029 On an off-boundary comma that coincides with a boundary event, the off-boundary rule SHALL take precedence.

Reset
REQ-030 While reset_n is low: ser_tx=0, tx_ready=0, rx_valid=0, rx_comma=0, rx_aligned=0, align_err=0, rx_symbol=0, window=0, RX state HUNT, all counters 0, TX slot loaded with RD- comma at index 0.
REQ-031 Reset assertion mid-operation SHALL discard the in-flight TX symbol and RX alignment immediately.

Configuration
REQ-032 Macro MGMT_PHY_LOOPBACK_EN adds input port loopback (1 bit); when loopback is high, RX samples the ser_tx register instead of ser_rx.
REQ-033 Without MGMT_PHY_LOOPBACK_EN, the loopback port SHALL not exist and RX SHALL always sample ser_rx.

Structure
REQ-034 Package mgmt_phy_pkg SHALL hold the K28.5 RD-/RD+ constants, the 7-bit comma patterns and the RX state enum.
REQ-035 One sub-module mgmt_phy_rx_align (window, comma detect, state machine); TX stays in the top module.

Verification
REQ-036 Loopback, tx_valid=0 after reset -> rx_aligned rises after 3 commas; thereafter rx_valid pulses every 10 clks with rx_comma=1.
REQ-037 Loopback locked, send tx_symbol=10'h2AA -> rx_symbol=10'h2AA, rx_comma=0, exactly one rx_valid for it.
REQ-038 tx_valid held high with 10'h155 -> tx_ready high once per 10 clks; each accepted symbol is seen once on ser_tx, LSB first.
REQ-039 External ser_rx, locked, insert one extra bit -> align_err pulse after 2nd off-boundary comma, rx_aligned=0, relock after 3 commas at new offset.
REQ-040 reset_n low for 1 clk mid-symbol -> all outputs at reset values next edge; relock requires a full 3-comma sequence.
REQ-041 Build without MGMT_PHY_LOOPBACK_EN, ser_rx tied to ser_tx externally -> same results as REQ-036.
